// File: rtl/extend_pipe.sv
// Immediate extender (zero / sign / upper / branch) feeding a STAGES-deep
// register pipeline with valid/ready handshakes on both sides.
module extend_pipe #(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned N_OUT  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data
);

    localparam int unsigned PAD = N_OUT - N_IN;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    logic [N_OUT-1:0] zero_ext;
    logic [N_OUT-1:0] sign_ext;
    logic [N_OUT-1:0] ext_result;

    assign zero_ext = {{PAD{1'b0}}, in_imm};
    assign sign_ext = {{PAD{in_imm[N_IN-1]}}, in_imm};

    always_comb begin
        ext_result = zero_ext;
        case (mode_e'(in_mode))
            MODE_ZERO:   ext_result = zero_ext;
            MODE_SIGN:   ext_result = sign_ext;
            MODE_UPPER:  ext_result = {in_imm, {PAD{1'b0}}};
            MODE_BRANCH: ext_result = sign_ext << 2;
            default:     ext_result = zero_ext;
        endcase
    end

    logic [STAGES-1:0] valid_q;
    logic [N_OUT-1:0]  data_q [STAGES];
    logic [STAGES-1:0] ready;

    // The ready chain is unrolled: stage i may load when the consumer takes
    // the output or any stage from i to the last is empty.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_ready
        assign ready[gi] = out_ready || !(&valid_q[STAGES-1:gi]);
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (ready[0]) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= ext_result;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (ready[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_extend_pipe.sv
// Bench for extend_pipe: three 16->32 instances (STAGES 1..3) sharing one
// input stream and scoreboarded as FIFOs, plus an 8->16 instance.
module tb_extend_pipe;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              flush    = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       in_imm   = '0;
    logic [1:0]        in_mode  = '0;
    logic [2:0]        out_ready_a = '1;
    logic [2:0]        in_ready_a;
    logic [2:0]        out_valid_a;
    logic [2:0][31:0]  out_data_a;

    logic        v8    = 1'b0;
    logic [7:0]  imm8  = '0;
    logic [1:0]  mode8 = '0;
    logic        or8   = 1'b1;
    logic        rdy8;
    logic        ov8;
    logic [15:0] od8;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] mq [3][256];
    int unsigned head [3];
    int unsigned tail [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        extend_pipe #(.N_IN(16), .N_OUT(32), .STAGES(g + 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[g]),
            .in_imm    (in_imm),
            .in_mode   (in_mode),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g])
        );
    end

    extend_pipe #(.N_IN(8), .N_OUT(16), .STAGES(1)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_imm    (imm8),
        .in_mode   (mode8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level reference: interpret the immediate as an integer and reduce mod 2^nout.
    function automatic logic [31:0] ref_ext(input int unsigned imm, input int unsigned mode,
                                            input int unsigned nin, input int unsigned nout);
        longint s, v, m;
        m = longint'(1) << nout;
        s = longint'(imm);
        if (imm >= (32'd1 << (nin - 1))) s = s - (longint'(1) << nin);
        case (mode)
            0:       v = longint'(imm);
            1:       v = s;
            2:       v = longint'(imm) * (longint'(1) << (nout - nin));
            default: v = s * 4;
        endcase
        v = ((v % m) + m) % m;
        return v[31:0];
    endfunction

    // Inputs are already set; check the cycle, update scoreboards, cross one edge.
    task automatic cycle();
        #1;
        for (int k = 0; k < 3; k++) begin
            int unsigned cnt;
            logic ir_exp;
            cnt    = tail[k] - head[k];
            ir_exp = out_ready_a[k] || (cnt < k + 1);
            chk($sformatf("in_ready_s%0d", k + 1), in_ready_a[k], ir_exp);
            if (out_valid_a[k]) begin
                chk($sformatf("out_valid_has_item_s%0d", k + 1), cnt != 0, 1'b1);
                if (cnt != 0)
                    chk($sformatf("out_data_s%0d", k + 1), out_data_a[k], mq[k][head[k] & 255]);
            end
            if (out_valid_a[k] && out_ready_a[k] && cnt != 0) head[k]++;
            if (in_valid && in_ready_a[k] && !flush) begin
                mq[k][tail[k] & 255] = ref_ext(in_imm, in_mode, 16, 32);
                tail[k]++;
            end
            if (flush) head[k] = tail[k];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_s%0d", k + 1), out_valid_a[k], 1'b0);
            chk($sformatf("rst_out_data_s%0d", k + 1), out_data_a[k], 32'h0);
            chk($sformatf("rst_in_ready_s%0d", k + 1), in_ready_a[k], 1'b1);
            head[k] = 0;
            tail[k] = 0;
        end
        chk("rst_out_data_n8", od8, 16'h0);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready_a = '1;
        repeat (6) cycle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain_left_s%0d", k + 1), tail[k] - head[k], 32'd0);
            chk($sformatf("drain_valid_s%0d", k + 1), out_valid_a[k], 1'b0);
        end
    endtask

    task automatic t_modes();
        logic [31:0] t1_exp [4];
        t1_exp = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        out_ready_a = '1;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            in_imm   = 16'h8001;
            in_mode  = 2'(m);
            cycle();
            chk($sformatf("modes_valid_%0d", m), out_valid_a[0], 1'b1);
            chk($sformatf("modes_data_%0d", m), out_data_a[0], t1_exp[m]);
        end
        drain();
    endtask

    initial begin
        logic [31:0] exp2 [10];
        logic [31:0] held;
        logic [7:0]  d_imm  [4];
        logic [1:0]  d_mode [4];
        logic [15:0] d_exp  [4];

        for (int k = 0; k < 3; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        @(negedge clk);
        do_reset();

        // Mode sequence on the single-stage pipe.
        t_modes();

        // Three-stage latency and back-to-back throughput.
        do_reset();
        out_ready_a = '1;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            if (cyc <= 10) begin
                in_valid = 1'b1;
                in_imm   = 16'($urandom);
                in_mode  = 2'($urandom);
                exp2[cyc - 1] = ref_ext(in_imm, in_mode, 16, 32);
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            chk($sformatf("lat_valid_%0d", cyc), out_valid_a[2], (cyc >= 3 && cyc <= 12));
            if (cyc >= 3 && cyc <= 12)
                chk($sformatf("lat_data_%0d", cyc), out_data_a[2], exp2[cyc - 3]);
        end
        drain();

        // Two-stage stall: output held, input blocked, nothing lost.
        do_reset();
        out_ready_a = '1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            cycle();
        end
        out_ready_a[1] = 1'b0;
        held = out_data_a[1];
        for (int i = 0; i < 5; i++) begin
            in_imm  = 16'($urandom);
            in_mode = 2'($urandom);
            #1;
            chk($sformatf("stall_in_ready_%0d", i), in_ready_a[1], 1'b0);
            cycle();
            chk($sformatf("stall_valid_%0d", i), out_valid_a[1], 1'b1);
            chk($sformatf("stall_hold_%0d", i), out_data_a[1], held);
        end
        out_ready_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_imm  = 16'($urandom);
            in_mode = 2'($urandom);
            cycle();
        end
        drain();

        // Flush with two items in flight and a concurrent input.
        do_reset();
        out_ready_a[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            cycle();
        end
        chk("flush_pre_valid", out_valid_a[1], 1'b1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'h1234;
        in_mode  = 2'b01;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid_a[1], 1'b0);
        chk("flush_empty_ready", in_ready_a[1], 1'b1);
        out_ready_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("flush_after_%0d", i), out_valid_a[1], 1'b0);
        end
        drain();

        // Asynchronous reset in the middle of a stall.
        do_reset();
        out_ready_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        #3;
        chk("areset_pre_valid", out_valid_a[1], 1'b1);
        do_reset();
        t_modes();

        // Random traffic with flushes and per-instance backpressure.
        do_reset();
        repeat (1500) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_imm   = 16'($urandom);
            in_mode  = 2'($urandom);
            flush    = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < 3; k++) out_ready_a[k] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        flush = 1'b0;
        drain();

        // Narrow instance: 8-bit immediate into 16-bit result.
        d_imm  = '{8'h80, 8'h7F, 8'h80, 8'h80};
        d_mode = '{2'b01, 2'b11, 2'b00, 2'b10};
        d_exp  = '{16'hFF80, 16'h01FC, 16'h0080, 16'h8000};
        chk("n8_in_ready", rdy8, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [15:0] e;
            v8 = 1'b1;
            if (i < 4) begin
                imm8  = d_imm[i];
                mode8 = d_mode[i];
                e     = d_exp[i];
            end else begin
                imm8  = 8'($urandom);
                mode8 = 2'($urandom);
                e     = 16'(ref_ext(imm8, mode8, 8, 16));
            end
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("n8_valid_%0d", i), ov8, 1'b1);
            chk($sformatf("n8_data_%0d", i), od8, e);
        end
        v8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
